// File: rtl/div_seq.sv
// Restoring divide/remainder sequencer for RV32M, sharing the execute-stage ALU.
// Optional DIV_EARLY_OUT_EN skips iteration when |a| < |b|.
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            alu_busy,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam int         CW       = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE
    } state_t;

    state_t          state, state_n;
    logic [1:0]      op, op_n;
    logic [XLEN-1:0] dvd, dvd_n;
    logic [XLEN-1:0] dvs, dvs_n;
    logic [XLEN-1:0] rem, rem_n;
    logic [XLEN-1:0] res, res_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            q_neg, q_neg_n;
    logic            r_neg, r_neg_n;
    logic            fin;
    logic [XLEN-1:0] rem_sh;
    logic            req_sgn;
`ifdef DIV_EARLY_OUT_EN
    logic            chk, chk_n;
`endif

    assign rem_sh      = {rem[XLEN-2:0], dvd[XLEN-1]};
    assign req_sgn     = ~req_op[0];
    assign resp_result = res;

    // ALU drive depends on state only, keeping alu_result out of any loop
    always_comb begin
        alu_busy   = 1'b0;
        alu_op     = '0;
        alu_a      = '0;
        alu_b      = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE:  req_ready = 1'b1;
            NEG_A: begin
                alu_busy = 1'b1;
                alu_op   = ALU_SUB;
                alu_b    = dvd;
            end
            NEG_B: begin
                alu_busy = 1'b1;
                alu_op   = ALU_SUB;
                alu_b    = dvs;
            end
            CMP: begin
                alu_busy = 1'b1;
                alu_op   = ALU_SLTU;
                alu_a    = rem_sh;
                alu_b    = dvs;
`ifdef DIV_EARLY_OUT_EN
                if (chk) alu_a = dvd;
`endif
            end
            SUB: begin
                alu_busy = 1'b1;
                alu_op   = ALU_SUB;
                alu_a    = rem;
                alu_b    = dvs;
            end
            FIX: begin
                alu_busy = 1'b1;
                alu_op   = ALU_SUB;
                alu_b    = op[1] ? rem : dvd;
            end
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        dvd_n   = dvd;
        dvs_n   = dvs;
        rem_n   = rem;
        res_n   = res;
        cnt_n   = cnt;
        q_neg_n = q_neg;
        r_neg_n = r_neg;
        fin     = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        chk_n   = chk;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n    = req_op;
                    dvd_n   = req_a;
                    dvs_n   = req_b;
                    rem_n   = '0;
                    cnt_n   = CW'(XLEN);
                    q_neg_n = req_sgn & (req_a[XLEN-1] ^ req_b[XLEN-1])
                              & (|req_b);
                    r_neg_n = req_sgn & req_a[XLEN-1];
`ifdef DIV_EARLY_OUT_EN
                    chk_n   = 1'b1;
`endif
                    if (req_b == '0) begin
                        res_n   = req_op[1] ? req_a : '1;
                        state_n = DONE;
                    end else if (req_sgn & req_a[XLEN-1]) begin
                        state_n = NEG_A;
                    end else if (req_sgn & req_b[XLEN-1]) begin
                        state_n = NEG_B;
                    end else begin
                        state_n = CMP;
                    end
                end
            end
            NEG_A: begin
                dvd_n   = alu_result;
                state_n = (~op[0] & dvs[XLEN-1]) ? NEG_B : CMP;
            end
            NEG_B: begin
                dvs_n   = alu_result;
                state_n = CMP;
            end
            CMP: begin
                // rem MSB is the carry out of the shift
                rem_n = rem_sh;
                dvd_n = {dvd[XLEN-2:0], 1'b0};
                if (rem[XLEN-1] | ~alu_result[0]) begin
                    state_n = SUB;
                end else begin
                    cnt_n = cnt - 1'b1;
                    fin   = (cnt == CW'(1));
                end
`ifdef DIV_EARLY_OUT_EN
                if (chk) begin
                    chk_n   = 1'b0;
                    rem_n   = rem;
                    dvd_n   = dvd;
                    cnt_n   = cnt;
                    state_n = CMP;
                    fin     = 1'b0;
                    if (alu_result[0]) begin
                        rem_n = dvd;
                        dvd_n = '0;
                        fin   = 1'b1;
                    end
                end
`endif
            end
            SUB: begin
                rem_n   = alu_result;
                dvd_n   = {dvd[XLEN-1:1], 1'b1};
                cnt_n   = cnt - 1'b1;
                fin     = (cnt == CW'(1));
                state_n = CMP;
            end
            FIX: begin
                res_n   = alu_result;
                state_n = DONE;
            end
            DONE: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (fin) begin
            if (op[1] ? r_neg : q_neg) begin
                state_n = FIX;
            end else begin
                res_n   = op[1] ? rem_n : dvd_n;
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op    <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            res   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            chk   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            op    <= op_n;
            dvd   <= dvd_n;
            dvs   <= dvs_n;
            rem   <= rem_n;
            res   <= res_n;
            cnt   <= cnt_n;
            q_neg <= q_neg_n;
            r_neg <= r_neg_n;
`ifdef DIV_EARLY_OUT_EN
            chk   <= chk_n;
`endif
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a behavioural shared-ALU model.
module tb_div_seq;

    localparam int         XLEN     = 32;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd3;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            alu_busy;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
            default:  alu_result = '0;
        endcase
    end

    div_seq #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .alu_busy    (alu_busy),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency/busy cycles, optionally stall the response
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat,
                         input int hold, input logic [31:0] first_b);
        int n, busy, rdy_bad;
        logic [31:0] fb, held;
        n = 0; busy = 0; rdy_bad = 0; fb = '0;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) fb = alu_b;
            if (resp_valid || n > 200) break;
            if (alu_busy) busy++;
            if (req_ready) rdy_bad++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".res"}, resp_result, exp);
        chk({tag, ".busy"}, 32'(busy), 32'(lat - 1));
        chk({tag, ".rdylow"}, 32'(rdy_bad), 32'd0);
        chk({tag, ".alu_idle"}, {27'b0, alu_busy, alu_op}, 32'd0);
        if (first_b != '0) chk({tag, ".alu_b1"}, fb, first_b);
        if (hold > 0) begin
            held = resp_result;
            rdy_bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid || req_ready || resp_result !== held)
                    rdy_bad++;
            end
            chk({tag, ".stall"}, 32'(rdy_bad), 32'd0);
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".idle"}, {30'b0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ctl", {28'b0, req_ready, resp_valid, alu_busy, 1'b0}, 32'h8);
        chk("rst.res", resp_result, 32'd0);
        chk("rst.alu", alu_a | alu_b | {28'b0, alu_op}, 32'd0);
        rst_n = 1'b1;

        do_op("divu100_7", 2'd1, 32'd100, 32'd7, 32'd14, 36 + EO, 0, '0);
        do_op("remu100_7", 2'd3, 32'd100, 32'd7, 32'd2, 36 + EO, 0, '0);
        do_op("div-7_2", 2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 37 + EO,
              0, 32'hFFFFFFF9);
        do_op("rem-7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 37 + EO,
              0, 32'hFFFFFFF9);
        do_op("div5_0", 2'd0, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0, '0);
        do_op("rem5_0", 2'd2, 32'd5, 32'd0, 32'd5, 1, 0, '0);
        do_op("div_ovf", 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
              36 + EO, 0, 32'h80000000);
        do_op("rem_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,
              37 + EO, 0, 32'h80000000);
        do_op("div7_-2", 2'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD,
              37 + EO, 0, 32'hFFFFFFFE);
        do_op("divu_max", 2'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
              2 * XLEN + 1 + EO, 10, '0);
        do_op("divu3_9", 2'd1, 32'd3, 32'd9, 32'd0, EO ? 2 : 33, 0, '0);
        do_op("remu3_9", 2'd3, 32'd3, 32'd9, 32'd3, EO ? 2 : 33, 0, '0);

        // Abort DIVU 1000/3 mid-iteration
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort.busy", 32'(alu_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.idle", {28'b0, req_ready, resp_valid, alu_busy, 1'b0},
            32'h8);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("abort.noresp", 32'(seen), 32'd0);
        do_op("divu9_3", 2'd1, 32'd9, 32'd3, 32'd3, 35 + EO, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
